// File: rtl/panel_pkg.sv
// Shared definitions for the BCM panel scanner: FSM states, default geometry, width helper.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package panel_pkg;

    localparam int DEF_BPP    = 5;
    localparam int DEF_COLS   = 64;
    localparam int DEF_ROWS   = 32;
    localparam int DEF_BASE_T = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_LATCH    = 3'd3,
        ST_DISPLAY  = 3'd4
    } state_e;

    // Counter/address width for a range of n values, never narrower than one bit
    function automatic int w_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bcm_plane_timer.sv
// Display-period timer for one bit-plane: counts BASE_T<<plane cycles and gates oe_n for the dimmed ON part.
// Latency: loads on start_i, oe_n_o valid from the next cycle, done_o high in the last display cycle.
// Backpressure: none; runs freely once started.
module bcm_plane_timer
    import panel_pkg::*;
#(
    parameter int BPP    = DEF_BPP,
    parameter int BASE_T = DEF_BASE_T
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_i,
    input  logic [w_of(BPP)-1:0] plane_i,
    input  logic [7:0]           brightness_i,
    output logic                 oe_n_o,
    output logic                 done_o
);

    localparam int MAXLEN = BASE_T << (BPP - 1);
    localparam int LW     = $clog2(MAXLEN + 1);

    logic [LW-1:0] len_d;
    logic [8:0]    bright_p1_d;
    logic [LW+8:0] prod_d;
    logic [LW-1:0] on_d;

    logic [LW-1:0] rem_q;
    logic [LW-1:0] thr_q;
    logic          active_q;
    logic          oe_n_q;

    // Plane length and ON time; the product is wide enough for 256x the longest plane
    always_comb begin
        len_d       = LW'(BASE_T) << plane_i;
        bright_p1_d = {1'b0, brightness_i} + 9'd1;
        prod_d      = (LW+9)'(len_d) * (LW+9)'(bright_p1_d);
        on_d        = LW'(prod_d >> 8);
    end

    // Down-counter; oe_n is low while the remaining count is above len-ON
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q    <= '0;
            thr_q    <= '0;
            active_q <= 1'b0;
            oe_n_q   <= 1'b1;
        end else if (start_i) begin
            rem_q    <= len_d;
            thr_q    <= len_d - on_d;
            active_q <= 1'b1;
            oe_n_q   <= (on_d == '0);
        end else if (active_q) begin
            if (rem_q == LW'(1)) begin
                rem_q    <= '0;
                active_q <= 1'b0;
                oe_n_q   <= 1'b1;
            end else begin
                rem_q    <= rem_q - LW'(1);
                oe_n_q   <= ~((rem_q - LW'(1)) > thr_q);
            end
        end
    end

    assign oe_n_o = oe_n_q;
    assign done_o = active_q && (rem_q == LW'(1));

endmodule

// File: rtl/panel_bcm_scanner.sv
// HUB75-style panel scanner with binary-coded modulation: prefetch, shift, latch, display per plane and row.
// Latency: pixel read one cycle after rd_en, shifted out on the following panel_clk rise (2 cycles after rd_en).
// Backpressure: none; the frame buffer must answer every rd_en on the next cycle.
module panel_bcm_scanner
    import panel_pkg::*;
#(
    parameter int BPP    = DEF_BPP,
    parameter int N_SUB  = 2,
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int BASE_T = DEF_BASE_T
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [7:0]              brightness,
    output logic                    rd_en,
    output logic [w_of(COLS)-1:0]   col_addr,
    output logic [w_of(ROWS)-1:0]   row_addr,
    input  logic [24*N_SUB-1:0]     pix_data,
    output logic [3*N_SUB-1:0]      rgb,
    output logic                    panel_clk,
    output logic                    lat,
    output logic                    oe_n,
    output logic [w_of(ROWS)-1:0]   addr,
    output logic                    frame_done
);

    localparam int CW = w_of(COLS);
    localparam int RW = w_of(ROWS);
    localparam int PW = w_of(BPP);

    state_e         state_q;
    logic           phase_q;
    logic [CW-1:0]  col_q;
    logic [RW-1:0]  row_q;
    logic [PW-1:0]  plane_q;
    logic [7:0]     bright_q;

    logic             rd_en_q;
    logic [CW-1:0]    col_addr_q;
    logic [RW-1:0]    row_addr_q;
    logic [3*N_SUB-1:0] rgb_q;
    logic             panel_clk_q;
    logic             lat_q;
    logic [RW-1:0]    addr_q;
    logic             frame_done_q;

    logic [2:0]         bit_sel;
    logic [7:0]         r_b, g_b, b_b;
    logic [3*N_SUB-1:0] rgb_d;
    logic               tmr_start;
    logic               tmr_oe_n;
    logic               tmr_done;

    // Plane p of an 8-bit channel lives at bit 8-BPP+p (MSB-aligned planes)
    assign bit_sel = 3'(8 - BPP) + 3'(plane_q);

    // Pick the current plane bit out of every channel of every sub-panel
    always_comb begin
        rgb_d = '0;
        r_b   = '0;
        g_b   = '0;
        b_b   = '0;
        for (int k = 0; k < N_SUB; k++) begin
            r_b          = pix_data[24*k+16 +: 8];
            g_b          = pix_data[24*k+8  +: 8];
            b_b          = pix_data[24*k    +: 8];
            rgb_d[3*k]   = r_b[bit_sel];
            rgb_d[3*k+1] = g_b[bit_sel];
            rgb_d[3*k+2] = b_b[bit_sel];
        end
    end

    // Scan FSM; outputs are registered, set on the edge entering the state they belong to
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            phase_q      <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            plane_q      <= '0;
            bright_q     <= '0;
            rd_en_q      <= 1'b0;
            col_addr_q   <= '0;
            row_addr_q   <= '0;
            rgb_q        <= '0;
            panel_clk_q  <= 1'b0;
            lat_q        <= 1'b0;
            addr_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            rd_en_q      <= 1'b0;
            lat_q        <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    panel_clk_q <= 1'b0;
                    if (enable) begin
                        bright_q   <= brightness;
                        row_q      <= '0;
                        plane_q    <= '0;
                        rd_en_q    <= 1'b1;
                        col_addr_q <= '0;
                        row_addr_q <= '0;
                        state_q    <= ST_PREFETCH;
                    end
                end
                ST_PREFETCH: begin
                    phase_q <= 1'b0;
                    col_q   <= '0;
                    state_q <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (!phase_q) begin
                        rgb_q       <= rgb_d;
                        panel_clk_q <= 1'b1;
                        phase_q     <= 1'b1;
                        if (col_q != CW'(COLS - 1)) begin
                            rd_en_q    <= 1'b1;
                            col_addr_q <= col_q + CW'(1);
                        end
                    end else begin
                        panel_clk_q <= 1'b0;
                        phase_q     <= 1'b0;
                        if (col_q == CW'(COLS - 1)) begin
                            lat_q   <= 1'b1;
                            addr_q  <= row_q;
                            state_q <= ST_LATCH;
                        end else begin
                            col_q <= col_q + CW'(1);
                        end
                    end
                end
                ST_LATCH: begin
                    state_q <= ST_DISPLAY;
                end
                ST_DISPLAY: begin
                    if (tmr_done) begin
                        col_addr_q <= '0;
                        if (plane_q != PW'(BPP - 1)) begin
                            plane_q    <= plane_q + PW'(1);
                            rd_en_q    <= 1'b1;
                            row_addr_q <= row_q;
                            state_q    <= ST_PREFETCH;
                        end else if (row_q != RW'(ROWS - 1)) begin
                            plane_q    <= '0;
                            row_q      <= row_q + RW'(1);
                            rd_en_q    <= 1'b1;
                            row_addr_q <= row_q + RW'(1);
                            state_q    <= ST_PREFETCH;
                        end else begin
                            frame_done_q <= 1'b1;
                            plane_q      <= '0;
                            row_q        <= '0;
                            row_addr_q   <= '0;
                            if (enable) begin
                                bright_q <= brightness;
                                rd_en_q  <= 1'b1;
                                state_q  <= ST_PREFETCH;
                            end else begin
                                state_q  <= ST_IDLE;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The timer is armed during LATCH so its first count lines up with the first DISPLAY cycle
    assign tmr_start = (state_q == ST_LATCH);

    bcm_plane_timer #(
        .BPP    (BPP),
        .BASE_T (BASE_T)
    ) u_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (tmr_start),
        .plane_i      (plane_q),
        .brightness_i (bright_q),
        .oe_n_o       (tmr_oe_n),
        .done_o       (tmr_done)
    );

    assign rd_en      = rd_en_q;
    assign col_addr   = col_addr_q;
    assign row_addr   = row_addr_q;
    assign rgb        = rgb_q;
    assign panel_clk  = panel_clk_q;
    assign lat        = lat_q;
    assign oe_n       = tmr_oe_n;
    assign addr       = addr_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_panel_bcm_scanner.sv
// Directed bench for panel_bcm_scanner at COLS=4, ROWS=2, BPP=2, BASE_T=4, N_SUB=2.
// Frame is 64 cycles: per row 14 (plane 0) + 18 (plane 1).
// Frame buffer model answers each rd_en on the following cycle.
module tb_panel_bcm_scanner;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [7:0]  brightness;
    logic        rd_en;
    logic [1:0]  col_addr;
    logic [0:0]  row_addr;
    logic [47:0] pix_data;
    logic [5:0]  rgb;
    logic        panel_clk;
    logic        lat;
    logic        oe_n;
    logic [0:0]  addr;
    logic        frame_done;

    int checks   = 0;
    int failures = 0;
    int mode     = 0;

    panel_bcm_scanner #(
        .BPP    (2),
        .N_SUB  (2),
        .COLS   (4),
        .ROWS   (2),
        .BASE_T (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .brightness (brightness),
        .rd_en      (rd_en),
        .col_addr   (col_addr),
        .row_addr   (row_addr),
        .pix_data   (pix_data),
        .rgb        (rgb),
        .panel_clk  (panel_clk),
        .lat        (lat),
        .oe_n       (oe_n),
        .addr       (addr),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // mode 0: sub0 R=0x80, rest 0. mode 1: sub0 R bits7:6 = column, sub1 G bits7:6 = {row,row}
    function automatic logic [47:0] mk_pix(input int m, input logic [1:0] c, input logic [0:0] r);
        logic [47:0] v;
        v = '0;
        if (m == 0) begin
            v[23:16] = 8'h80;
        end else begin
            v[23:16] = {c[1], c[0], 6'b0};
            v[39:32] = {r[0], r[0], 6'b0};
        end
        return v;
    endfunction

    // Expected rgb for shift segment seg (row = seg/2, plane = seg%2) and column c
    function automatic logic [5:0] exp_rgb(input int m, input int seg, input int c);
        logic [5:0] e;
        int p;
        int r;
        p = seg % 2;
        r = seg / 2;
        e = '0;
        if (m == 0) begin
            e[0] = (p == 1);
        end else begin
            e[0] = ((c >> p) & 1) == 1;
            e[4] = (r & 1) == 1;
        end
        return e;
    endfunction

    initial pix_data = '0;
    always @(posedge clk) begin
        if (rd_en) pix_data <= mk_pix(mode, col_addr, row_addr);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Step until frame_done is seen or the budget runs out; n is the number of steps taken
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            step();
            n++;
            if (frame_done === 1'b1) break;
        end
    endtask

    // Called in the first cycle of a frame (PREFETCH); checks a whole 64-cycle frame
    task automatic observe_frame(input int m, input int lo0, input int lo1);
        int lows[4];
        int latad[4];
        int cols[5];
        int seg, sh, lat_bad, rd_bad, fd_mid, oe_stray;
        logic pclk_p, rd1, rd2;
        logic [1:0] ca1, ca2;
        seg = -1; lat_bad = 0; rd_bad = 0; fd_mid = 0; oe_stray = 0;
        pclk_p = 1'b0; rd1 = 1'b0; rd2 = 1'b0; ca1 = '0; ca2 = '0;
        for (int i = 0; i < 4; i++) begin lows[i] = 0; latad[i] = -1; end
        for (int i = 0; i < 5; i++) cols[i] = 0;
        for (int i = 0; i < 64; i++) begin
            if (i > 0) begin
                step();
                if (frame_done !== 1'b0) fd_mid++;
            end
            if (lat === 1'b1) begin
                seg++;
                if (seg < 4) latad[seg] = int'(addr);
                if (oe_n !== 1'b1) lat_bad++;
            end
            if (oe_n === 1'b0) begin
                if (seg >= 0 && seg < 4) lows[seg]++;
                else oe_stray++;
            end
            if (panel_clk === 1'b1 && pclk_p === 1'b0) begin
                sh = seg + 1;
                if (sh < 4) begin
                    if (!(rd2 === 1'b1 && int'(ca2) == cols[sh])) rd_bad++;
                    chk("rgb_shift", rgb, exp_rgb(m, sh, cols[sh]));
                end
                cols[sh]++;
            end
            pclk_p = panel_clk;
            rd2 = rd1; ca2 = ca1;
            rd1 = rd_en; ca1 = col_addr;
        end
        step();
        chk("frame_done_at_64", frame_done, 1);
        chk("frame_done_mid", fd_mid, 0);
        chk("oe_low_r0p0", lows[0], lo0);
        chk("oe_low_r0p1", lows[1], lo1);
        chk("oe_low_r1p0", lows[2], lo0);
        chk("oe_low_r1p1", lows[3], lo1);
        chk("oe_low_outside_display", oe_stray, 0);
        chk("lat_addr_0", latad[0], 0);
        chk("lat_addr_1", latad[1], 0);
        chk("lat_addr_2", latad[2], 1);
        chk("lat_addr_3", latad[3], 1);
        chk("lat_count", seg + 1, 4);
        chk("lat_with_oe_low", lat_bad, 0);
        chk("cols_seg0", cols[0], 4);
        chk("cols_seg3", cols[3], 4);
        chk("cols_extra", cols[4], 0);
        chk("rd_en_2cyc_before_pclk", rd_bad, 0);
    endtask

    initial begin
        int n;
        int cnt_fd, cnt_oe, cnt_rd, cnt_lat;
        rst_n = 1'b0;
        enable = 1'b0;
        brightness = 8'd0;
        mode = 0;

        // Reset state
        step();
        step();
        chk("rst_oe_n", oe_n, 1);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_lat", lat, 0);
        chk("rst_panel_clk", panel_clk, 0);
        chk("rst_rgb", rgb, 0);
        chk("rst_addr", addr, 0);
        chk("rst_col_addr", col_addr, 0);
        chk("rst_row_addr", row_addr, 0);
        chk("rst_frame_done", frame_done, 0);
        rst_n = 1'b1;
        step();
        step();
        step();
        chk("idle_rd_en", rd_en, 0);
        chk("idle_oe_n", oe_n, 1);

        // Full brightness: first frame, then a checked frame
        brightness = 8'd255;
        enable = 1'b1;
        wait_done(200, n);
        chk("first_frame_len", n, 65);
        observe_frame(0, 4, 8);

        // Half brightness with column/row pattern (new value takes effect next frame)
        brightness = 8'd127;
        mode = 1;
        wait_done(200, n);
        chk("frame_len_b255", n, 64);
        observe_frame(1, 2, 4);

        // Zero brightness: oe_n never low, frame length unchanged
        brightness = 8'd0;
        wait_done(200, n);
        chk("frame_len_b127", n, 64);
        observe_frame(1, 0, 0);

        // Reset during plane-1 display of row 1 (frame cycle 58)
        brightness = 8'd255;
        wait_done(200, n);
        chk("frame_len_b0", n, 64);
        for (int i = 0; i < 58; i++) step();
        chk("pre_reset_oe_low", oe_n, 0);
        rst_n = 1'b0;
        #1;
        chk("async_rst_oe_n", oe_n, 1);
        chk("async_rst_rd_en", rd_en, 0);
        chk("async_rst_rgb", rgb, 0);
        step();
        rst_n = 1'b1;
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (lat === 1'b1) break;
        end
        chk("post_reset_first_lat_cycle", n, 10);
        chk("post_reset_first_lat_addr", addr, 0);
        wait_done(200, n);
        chk("post_reset_frame_rest", n, 55);

        // Enable dropped at frame cycle 10: frame completes, then idle
        for (int i = 0; i < 10; i++) step();
        enable = 1'b0;
        wait_done(200, n);
        chk("disable_frame_rest", n, 54);
        chk("disable_no_prefetch", rd_en, 0);
        cnt_fd = 0; cnt_oe = 0; cnt_rd = 0; cnt_lat = 0;
        for (int i = 0; i < 80; i++) begin
            step();
            if (frame_done !== 1'b0) cnt_fd++;
            if (oe_n !== 1'b1) cnt_oe++;
            if (rd_en !== 1'b0) cnt_rd++;
            if (lat !== 1'b0) cnt_lat++;
        end
        chk("idle_frame_done", cnt_fd, 0);
        chk("idle_oe_low", cnt_oe, 0);
        chk("idle_rd_en_count", cnt_rd, 0);
        chk("idle_lat_count", cnt_lat, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
